// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame scheduler: FSM state encoding,
// frame type codes and the frame-length legality rule.
package frame_sched_pkg;

    localparam int LEN_W  = 16;
    localparam int TYPE_W = 4;
    localparam int CNT_W  = 16;

    typedef logic [LEN_W-1:0]  len_t;
    typedef logic [TYPE_W-1:0] ftype_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        PARAM,
        WAIT_DONE,
        GAP
    } state_t;

    localparam ftype_t TYPE_CTRL = 4'd1;
    localparam ftype_t TYPE_DATA = 4'd2;

    // A zero-length frame is meaningless to the transmitter, so it is rejected too.
    function automatic logic len_legal(input len_t len, input int max_len);
        return (len != '0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/frame_sched_if.sv
// Request/grant and transmitter-side signal bundle of the frame scheduler.
// The requester/transmitter side uses 'master', the scheduler uses 'slave'.
interface frame_sched_if;
    import frame_sched_pkg::*;

    logic   en;
    logic   req0;
    logic   req1;
    len_t   len0;
    len_t   len1;
    ftype_t type0;
    ftype_t type1;
    logic   gnt0;
    logic   gnt1;
    logic   tx_done;
    logic   new_frame;
    logic   frame_vld;
    len_t   frame_len;
    ftype_t frame_type;
    logic   err_len;
    logic   err_tmo;
    logic   busy;
    cnt_t   frame_cnt;

    modport master (
        output en, req0, req1, len0, len1, type0, type1, tx_done,
        input  gnt0, gnt1, new_frame, frame_vld, frame_len, frame_type,
               err_len, err_tmo, busy, frame_cnt
    );

    modport slave (
        input  en, req0, req1, len0, len1, type0, type1, tx_done,
        output gnt0, gnt1, new_frame, frame_vld, frame_len, frame_type,
               err_len, err_tmo, busy, frame_cnt
    );

endinterface

// File: rtl/frame_sched_arb.sv
// Two-port arbiter: fixed priority to the control port (0), with a starvation
// counter that hands one grant to the data port (1) after STARVE_LIMIT port-0 wins.
module frame_sched_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic pick1,
    output logic any_req
);

    logic [15:0] starve_cnt;

    assign any_req = req0 | req1;
    assign pick1   = req1 && (!req0 || (starve_cnt == 16'(STARVE_LIMIT)));

    // Only port-0 wins taken while port 1 is actually waiting count as starvation.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!req1 || (take && pick1)) begin
            starve_cnt <= '0;
        end else if (take) begin
            starve_cnt <= starve_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/frame_sched.sv
// Frame scheduler: grants one of two requesters, announces the frame to the
// transmitter, waits for its end (with timeout) and enforces an inter-frame gap.
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter int IFS_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 170000,
    parameter int MAX_LEN        = 4095,
    parameter int STARVE_LIMIT   = 4
) (
    input logic          clk,
    input logic          rst,
    frame_sched_if.slave bus
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST = 32'(IFS_CYCLES - 1);

    state_t      state;
    len_t        lat_len;
    ftype_t      lat_type;
    logic [31:0] tmo_cnt;
    logic [31:0] gap_cnt;

    logic   pick1;
    logic   any_req;
    logic   decide;
    len_t   win_len;
    ftype_t win_type;

    // A gnt still showing means the requester has not yet dropped its req,
    // so that cycle must not be mistaken for a fresh request.
    assign decide   = (state == IDLE) && bus.en && any_req && !(bus.gnt0 || bus.gnt1);
    assign win_len  = pick1 ? bus.len1  : bus.len0;
    assign win_type = pick1 ? bus.type1 : bus.type0;

    frame_sched_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req0    (bus.req0),
        .req1    (bus.req1),
        .take    (decide),
        .pick1   (pick1),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lat_len        <= '0;
            lat_type       <= '0;
            tmo_cnt        <= '0;
            gap_cnt        <= '0;
            bus.gnt0       <= 1'b0;
            bus.gnt1       <= 1'b0;
            bus.new_frame  <= 1'b0;
            bus.frame_vld  <= 1'b0;
            bus.frame_len  <= '0;
            bus.frame_type <= '0;
            bus.err_len    <= 1'b0;
            bus.err_tmo    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_cnt  <= '0;
        end else begin
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.new_frame <= 1'b0;
            bus.frame_vld <= 1'b0;
            bus.err_len   <= 1'b0;
            bus.err_tmo   <= 1'b0;

            case (state)
                IDLE: begin
                    if (decide) begin
                        bus.gnt0 <= !pick1;
                        bus.gnt1 <= pick1;
                        lat_len  <= win_len;
                        lat_type <= win_type;
                        // Illegal lengths are acknowledged but never reach the transmitter.
                        if (len_legal(win_len, MAX_LEN)) begin
                            bus.new_frame <= 1'b1;
                            bus.busy      <= 1'b1;
                            state         <= START;
                        end else begin
                            bus.err_len <= 1'b1;
                        end
                    end
                end

                START: begin
                    bus.frame_vld  <= 1'b1;
                    bus.frame_len  <= lat_len;
                    bus.frame_type <= lat_type;
                    bus.frame_cnt  <= bus.frame_cnt + 1'b1;
                    state          <= PARAM;
                end

                PARAM: begin
                    // The PARAM cycle itself counts towards the timeout.
                    tmo_cnt <= 32'd1;
                    state   <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (bus.tx_done || (tmo_cnt >= TMO_LAST)) begin
                        bus.err_tmo <= !bus.tx_done;
                        if (IFS_CYCLES == 0) begin
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            gap_cnt <= GAP_LAST;
                            state   <= GAP;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == '0) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 SHALL have parameter IFS_CYCLES, default 200: idle gap inserted after each frame, in clk cycles.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 170000: maximum wait for tx_done.
REQ-003 SHALL have parameter MAX_LEN, default 4095: largest legal frame length.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4: consecutive port-0 grants allowed while port 1 waits.
REQ-005 SHALL have ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  permits new grants.
- req0, req1  in  1 each  frame requests; port 0 is the control port, port 1 is the data port.
- len0, len1  in  16 each  requested frame length, held while the matching req is high.
- type0, type1  in  4 each  requested frame type, held while the matching req is high.
- gnt0, gnt1  out  1 each  one-cycle acceptance pulse.
- tx_done  in  1  transmitter end-of-frame pulse.
- new_frame  out  1  one-cycle frame-start pulse to the transmitter.
- frame_vld  out  1  one-cycle parameter strobe.
- frame_len  out  16  frame length sent to the transmitter.
- frame_type  out  4  frame type sent to the transmitter.
- err_len  out  1  pulse: request rejected for illegal length.
- err_tmo  out  1  pulse: tx_done timeout.
- busy  out  1  high in any state other than IDLE.
- frame_cnt  out  16  count of frames issued.

Function
REQ-006 SHALL implement FSM states IDLE, START, PARAM, WAIT_DONE, GAP.
REQ-007 IDLE: when en=1 and any req is high, SHALL select a winner, pulse its gnt next cycle and enter START; with en=0 SHALL stay in IDLE.
REQ-008 Arbitration SHALL be fixed priority to port 0.
REQ-009 When req1 is pending and the starvation counter equals STARVE_LIMIT, port 1 SHALL win instead.
REQ-010 The starvation counter SHALL increment on each port-0 grant made while req1=1, and SHALL clear on any port-1 grant or whenever req1=0.
REQ-011 On the grant, the winner's len/type SHALL be latched; later changes on the request inputs SHALL be ignored for that frame.
REQ-012 If the latched len is 0 or greater than MAX_LEN, then in the cycle after the decision the block SHALL raise gnt and err_len for one cycle, SHALL NOT raise new_frame, and SHALL return to IDLE; frame_cnt SHALL be unchanged.
REQ-013 START SHALL last one cycle, with new_frame=1 and the gnt pulse in the same cycle; the next state is PARAM.
REQ-014 PARAM SHALL last one cycle, with frame_vld=1 and frame_len/frame_type driving the latched values; frame_cnt SHALL increment (wrapping 0xFFFF to 0); the next state is WAIT_DONE.
REQ-015 Latency SHALL be: request sampled in cycle N, new_frame in N+1, frame_vld in N+2.
REQ-016 frame_len/frame_type SHALL hold their values until the next PARAM.
REQ-017 WAIT_DONE SHALL leave on tx_done=1 and enter GAP.
REQ-018 tx_done arriving in any state other than WAIT_DONE SHALL be ignored.
REQ-019 In WAIT_DONE, after TIMEOUT_CYCLES cycles without tx_done, the block SHALL pulse err_tmo and enter GAP.
REQ-020 If tx_done coincides with the final timeout cycle, tx_done SHALL win and no err_tmo is raised.
REQ-021 GAP SHALL last exactly IFS_CYCLES cycles and then return to IDLE.
REQ-022 A request may be granted in the first IDLE cycle after GAP.
REQ-023 With IFS_CYCLES=0, the block SHALL return straight to IDLE.
REQ-024 Deasserting en mid-frame SHALL NOT abort the current frame; it only blocks the next grant.
REQ-025 Each gnt SHALL be asserted at most once per request; a requester SHALL drop req in the cycle after its gnt, and a req still high afterwards is treated as a new request.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst=1 at a rising clk edge SHALL force IDLE from any state, including mid-frame.
REQ-028 Reset SHALL clear to 0: every pulse output, busy, frame_len, frame_type, frame_cnt, the starvation counter and all timers.
REQ-029 No output SHALL pulse in the cycle following reset release.

Structure
REQ-030 The state encoding and the frame_type constants (for example control and data types) SHALL live in the shared global define file.
REQ-031 A single sub-module, frame_sched_arb, SHALL hold the two-port priority/starvation arbiter; the FSM and timers SHALL stay in frame_sched.
REQ-032 Target size SHALL be 150-300 lines of RTL.

Verification
REQ-033 Single request: req1=1, len1=100, type1=2 at cycle N -> gnt1 and new_frame at N+1; frame_vld with frame_len=100 and frame_type=2 at N+2; frame_cnt=1.
REQ-034 Contention: req0 and req1 held continuously with STARVE_LIMIT=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1.
REQ-035 Illegal length: len0=0, then len0=4096 -> gnt0 and err_len pulse each time, no new_frame, frame_cnt unchanged.
REQ-036 Timeout: TIMEOUT_CYCLES=10, tx_done withheld -> err_tmo exactly 10 cycles after frame_vld, then IFS_CYCLES idle cycles; tx_done on cycle 10 -> no err_tmo.
REQ-037 Reset mid-frame: rst asserted in WAIT_DONE -> next cycle busy=0 and frame_cnt=0; a later request gives normal N+1/N+2 timing.
REQ-038 Gap and enable: IFS_CYCLES=3 with req held -> successive new_frame pulses spaced by the tx_done wait plus 3 cycles plus 2; en=0 -> no gnt while en stays low.
